// File: rtl/raytracing_scheduler_pkg.sv
// Types shared by the raytracing line scheduler: the circle record, the FSM
// state encoding, and the SPI packet geometry.
package Types;

    localparam int COORD_W      = 12;
    localparam int CIRCLE_W     = 3 * COORD_W;
    localparam int COLOR_DEF_W  = 12;
    localparam int PKT_LEN      = 4;
    localparam logic [COORD_W-1:0] RESET_RADIUS = 12'd20;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] r;
    } circle_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_RENDER    = 3'd3,
        S_SWAP      = 3'd4
    } state_t;

    // Power-up scene: one circle of radius 20 at the origin, remaining slots empty.
    function automatic circle_t reset_circle(input int slot);
        circle_t c;
        c = '0;
        if (slot == 0) c.r = RESET_RADIUS;
        return c;
    endfunction

endpackage

// File: rtl/raytracing_scheduler_scene_loader.sv
// SPI packet decoder {slot, x, y, r} feeding the shadow circle table.
// Packets naming a slot beyond the table are consumed and dropped.
module scene_loader
    import Types::*;
#(
    parameter int N_CIRCLES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          recv_dv_i,
    input  logic [7:0]                    recv_byte_i,
    output logic [N_CIRCLES*CIRCLE_W-1:0] shadow_o
);

    localparam int BC_W = $clog2(PKT_LEN);

    logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      x_q, x_d;
    logic [7:0]      y_q, y_d;
    circle_t         shadow_q [N_CIRCLES];
    circle_t         shadow_d [N_CIRCLES];

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        x_d        = x_q;
        y_d        = y_q;
        shadow_d   = shadow_q;
        if (recv_dv_i) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == BC_W'(0)) idx_d = recv_byte_i;
            if (byte_cnt_q == BC_W'(1)) x_d   = recv_byte_i;
            if (byte_cnt_q == BC_W'(2)) y_d   = recv_byte_i;
            if (byte_cnt_q == BC_W'(PKT_LEN - 1)) begin
                for (int k = 0; k < N_CIRCLES; k++) begin
                    if (idx_q == 8'(k)) begin
                        shadow_d[k] = '{x: {4'd0, x_q}, y: {4'd0, y_q}, r: {4'd0, recv_byte_i}};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            byte_cnt_q <= '0;
            idx_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            // NOTE: the table is a handful of registers with a defined power-up
            // scene, so it is reset like any other state rather than left as RAM.
            for (int k = 0; k < N_CIRCLES; k++) shadow_q[k] <= reset_circle(k);
        end else begin
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            shadow_q   <= shadow_d;
        end
    end

    always_comb begin
        shadow_o = '0;
        for (int k = 0; k < N_CIRCLES; k++) shadow_o[k*CIRCLE_W +: CIRCLE_W] = shadow_q[k];
    end

endmodule

// File: rtl/raytracing_scheduler.sv
// Line scheduler: hands one VGA line to the worker pool, double-buffers the result
// and latches new scenes at frame start. Optional watchdog: define SCHED_TIMEOUT_EN.
module raytracing_scheduler
    import Types::*;
#(
    parameter int N_WORKERS      = 20,
    parameter int JOBS           = 640,
    parameter int N_CIRCLES      = 4,
    parameter int COLOR_W        = COLOR_DEF_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          CLK100MHZ,
    input  logic                          ck_rst_,
    input  logic                          next_line,
    input  logic [9:0]                    next_y,
    input  logic                          recv_dv,
    input  logic [7:0]                    recv_byte,
    input  logic [N_WORKERS-1:0]          worker_busy,
    input  logic [JOBS*COLOR_W-1:0]       worker_line,
    output logic                          activate,
    output logic [9:0]                    job_y,
    output logic [N_CIRCLES*CIRCLE_W-1:0] scene,
    output logic [JOBS*COLOR_W-1:0]       line_color,
    output logic                          overrun,
    output logic [3:0]                    status
);

    state_t                          state_q, state_d;
    logic                            activate_q, activate_d;
    logic [9:0]                      job_y_q, job_y_d;
    logic [JOBS*COLOR_W-1:0]         back_q, back_d;
    logic [JOBS*COLOR_W-1:0]         line_q, line_d;
    logic                            overrun_q, overrun_d;
    logic [7:0]                      ovr_cnt_q, ovr_cnt_d;
    logic [N_CIRCLES*CIRCLE_W-1:0]   scene_q, scene_d;
    logic [N_CIRCLES*CIRCLE_W-1:0]   shadow;
    logic                            timeout;

    scene_loader #(.N_CIRCLES(N_CIRCLES)) u_scene_loader (
        .clk_i       (CLK100MHZ),
        .rst_ni      (ck_rst_),
        .recv_dv_i   (recv_dv),
        .recv_byte_i (recv_byte),
        .shadow_o    (shadow)
    );

`ifdef SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             in_flight;

    assign in_flight = (state_q == S_WAIT_BUSY) || (state_q == S_RENDER);
    assign tmo_d     = in_flight ? tmo_q + 1'b1 : '0;
    assign timeout   = in_flight && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst_) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK100MHZ) begin
        // NOTE: every register here uses <= so all state updates see pre-edge values.
        if (!ck_rst_) begin
            state_q    <= S_IDLE;
            activate_q <= 1'b0;
            job_y_q    <= '0;
            back_q     <= '0;
            line_q     <= '0;
            overrun_q  <= 1'b0;
            ovr_cnt_q  <= '0;
            for (int k = 0; k < N_CIRCLES; k++) scene_q[k*CIRCLE_W +: CIRCLE_W] <= reset_circle(k);
        end else begin
            state_q    <= state_d;
            activate_q <= activate_d;
            job_y_q    <= job_y_d;
            back_q     <= back_d;
            line_q     <= line_d;
            overrun_q  <= overrun_d;
            ovr_cnt_q  <= ovr_cnt_d;
            scene_q    <= scene_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (next_line)          state_d = S_ARM;
            S_ARM:       if (worker_busy == '0)  state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (|worker_busy)       state_d = S_RENDER;
            S_RENDER:    if (worker_busy == '0)  state_d = S_SWAP;
            S_SWAP:                              state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_IDLE;
    end

    always_comb begin
        activate_d = activate_q;
        job_y_d    = job_y_q;
        back_d     = back_q;
        line_d     = line_q;
        overrun_d  = overrun_q;
        ovr_cnt_d  = ovr_cnt_q;
        scene_d    = scene_q;
        // A request arriving while a line is in flight is dropped and counted.
        if (next_line && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
        unique case (state_q)
            S_IDLE: if (next_line) begin
                job_y_d = next_y;
                if (next_y == 10'd0) scene_d = shadow;
            end
            S_ARM:    if (worker_busy == '0) activate_d = 1'b1;
            S_RENDER: if (worker_busy == '0) begin
                back_d     = worker_line;
                activate_d = 1'b0;
            end
            S_SWAP:   line_d = back_q;
            default:  ;
        endcase
        if (timeout) begin
            activate_d = 1'b0;
            overrun_d  = 1'b1;
        end
    end

    assign activate   = activate_q;
    assign job_y      = job_y_q;
    assign scene      = scene_q;
    assign line_color = line_q;
    assign overrun    = overrun_q;
    assign status     = {overrun_q, state_q};

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Directed bench for raytracing_scheduler: table of line renders plus hand-written
// sequences for scene loading, overrun, reset abort and the watchdog.
module tb_raytracing_scheduler;

    localparam int N_WORKERS = 20;
    localparam int JOBS      = 640;
    localparam int N_CIRCLES = 4;
    localparam int COLOR_W   = 12;
    localparam int LW        = JOBS * COLOR_W;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  next_line = 1'b0;
    logic [9:0]            next_y = '0;
    logic                  recv_dv = 1'b0;
    logic [7:0]            recv_byte = '0;
    logic [N_WORKERS-1:0]  worker_busy = '0;
    logic [LW-1:0]         worker_line = '0;
    logic                  activate;
    logic [9:0]            job_y;
    logic [N_CIRCLES*36-1:0] scene;
    logic [LW-1:0]         line_color;
    logic                  overrun;
    logic [3:0]            status;

    int checks = 0;
    int errors = 0;
    logic [11:0] last_col = 12'h000;

    raytracing_scheduler #(
        .N_WORKERS(N_WORKERS), .JOBS(JOBS), .N_CIRCLES(N_CIRCLES),
        .COLOR_W(COLOR_W), .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK100MHZ(clk), .ck_rst_(rst_n), .next_line(next_line), .next_y(next_y),
        .recv_dv(recv_dv), .recv_byte(recv_byte), .worker_busy(worker_busy),
        .worker_line(worker_line), .activate(activate), .job_y(job_y), .scene(scene),
        .line_color(line_color), .overrun(overrun), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  y;
        int          busy_cyc;
        logic [11:0] col;
        logic [9:0]  exp_y;
        logic [11:0] exp_px;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] fill(input logic [11:0] col);
        logic [LW-1:0] v;
        for (int p = 0; p < JOBS; p++) v[p*COLOR_W +: COLOR_W] = col;
        return v;
    endfunction

    function automatic int count_bad(input logic [11:0] col);
        int n = 0;
        for (int p = 0; p < JOBS; p++) if (line_color[p*COLOR_W +: COLOR_W] !== col) n++;
        return n;
    endfunction

    function automatic logic [35:0] slot(input int k);
        return scene[k*36 +: 36];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); recv_dv = 1'b1; recv_byte = b;
        @(negedge clk); recv_dv = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] i, input logic [7:0] x, input logic [7:0] y, input logic [7:0] r);
        send_byte(i); send_byte(x); send_byte(y); send_byte(r);
    endtask

    task automatic request(input logic [9:0] y);
        @(negedge clk); next_line = 1'b1; next_y = y;
        @(negedge clk); next_line = 1'b0;
    endtask

    task automatic wait_activate(input string tag);
        int n = 0;
        while (activate !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_activate_hi"}, activate, 1'b1);
    endtask

    // Drives the worker pool for one line; optionally re-requests during the render.
    task automatic finish_line(input int busy_cyc, input logic [11:0] col, input logic [9:0] exp_y,
                               input int ovr_cyc, input string tag);
        int n;
        worker_line = fill(col);
        wait_activate(tag);
        check({tag, "_job_y"}, job_y, exp_y);
        @(negedge clk); worker_busy = '1;
        for (int c = 0; c < busy_cyc; c++) begin
            next_line = (c < ovr_cyc);
            next_y    = 10'd9;
            @(negedge clk);
        end
        next_line = 1'b0;
        check({tag, "_stable_px0"}, line_color[COLOR_W-1:0], last_col);
        worker_busy = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (status[2:0] !== 3'd0 && n < 20);
        check({tag, "_back_idle"}, status[2:0], 3'd0);
        check({tag, "_activate_lo"}, activate, 1'b0);
        check({tag, "_px0"}, line_color[COLOR_W-1:0], col);
        check({tag, "_bad_px"}, count_bad(col), 0);
        last_col = col;
    endtask

    vec_t vecs [4];

    initial begin
        int n;
        vecs[0] = '{y: 10'd5,    busy_cyc: 10, col: 12'hABC, exp_y: 10'd5,    exp_px: 12'hABC};
        vecs[1] = '{y: 10'd1023, busy_cyc: 1,  col: 12'hFFF, exp_y: 10'd1023, exp_px: 12'hFFF};
        vecs[2] = '{y: 10'd1,    busy_cyc: 3,  col: 12'h000, exp_y: 10'd1,    exp_px: 12'h000};
        vecs[3] = '{y: 10'd639,  busy_cyc: 7,  col: 12'h5A5, exp_y: 10'd639,  exp_px: 12'h5A5};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_activate", activate, 1'b0);
        check("rst_job_y", job_y, 10'd0);
        check("rst_line_bad", count_bad(12'h000), 0);
        check("rst_status", status, 4'h0);
        check("rst_slot0", slot(0), 36'h000_000_014);
        check("rst_slot1", slot(1), 36'h0);
        check("rst_slot3", slot(3), 36'h0);

        for (int i = 0; i < 4; i++) begin
            request(vecs[i].y);
            finish_line(vecs[i].busy_cyc, vecs[i].col, vecs[i].exp_y, 0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_exp_px", i), line_color[COLOR_W-1:0], vecs[i].exp_px);
            check($sformatf("vec%0d_overrun", i), overrun, 1'b0);
        end

        // Shadow writes stay invisible until a line-0 request.
        send_pkt(8'h01, 8'h10, 8'h20, 8'h05);
        check("pkt_slot1_hidden", slot(1), 36'h0);
        request(10'd3);
        finish_line(2, 12'h111, 10'd3, 0, "mid");
        check("pkt_slot1_still_hidden", slot(1), 36'h0);
        send_pkt(8'h07, 8'h11, 8'h22, 8'h33);
        send_pkt(8'h02, 8'h01, 8'h02, 8'h03);
        request(10'd0);
        check("commit_slot0", slot(0), 36'h000_000_014);
        check("commit_slot1", slot(1), 36'h010_020_005);
        check("commit_slot2", slot(2), 36'h001_002_003);
        check("commit_slot3", slot(3), 36'h0);
        finish_line(2, 12'h222, 10'd0, 0, "frame0");

        // Last packet byte lands on the same edge as the commit: shadow only.
        send_byte(8'h03); send_byte(8'hAA); send_byte(8'hBB);
        @(negedge clk); recv_dv = 1'b1; recv_byte = 8'hCC; next_line = 1'b1; next_y = 10'd0;
        @(negedge clk); recv_dv = 1'b0; next_line = 1'b0;
        check("race_slot3_old", slot(3), 36'h0);
        finish_line(2, 12'h333, 10'd0, 0, "race");
        request(10'd0);
        check("race_slot3_new", slot(3), 36'h0AA_0BB_0CC);
        finish_line(2, 12'h444, 10'd0, 0, "frame1");

        request(10'd7);
        finish_line(10, 12'h123, 10'd7, 1, "ovr");
        check("ovr_flag", overrun, 1'b1);
        check("ovr_count", dut.ovr_cnt_q, 8'd1);
        check("ovr_status", status, 4'h8);
        check("ovr_job_y_kept", job_y, 10'd7);

        request(10'd8);
        finish_line(305, 12'h456, 10'd8, 300, "sat");
        check("sat_count", dut.ovr_cnt_q, 8'd255);

        request(10'd4);
        wait_activate("abort");
        @(negedge clk); worker_busy = '1;
        repeat (3) @(negedge clk);
        check("abort_in_render", status[2:0], 3'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_status", status, 4'h0);
        check("abort_activate", activate, 1'b0);
        check("abort_line_bad", count_bad(12'h000), 0);
        check("abort_count", dut.ovr_cnt_q, 8'd0);
        check("abort_slot1", slot(1), 36'h0);
        rst_n = 1'b1; worker_busy = '0; last_col = 12'h000;
        @(negedge clk);

        request(10'd6);
        worker_line = fill(12'hEEE);
        wait_activate("tmo");
        @(negedge clk); worker_busy = '1;
`ifdef SCHED_TIMEOUT_EN
        n = 1;
        while (activate !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check("tmo_cycles", n, 64);
        check("tmo_status", status, 4'h8);
        check("tmo_line_bad", count_bad(12'h000), 0);
        worker_busy = '0;
        repeat (2) @(negedge clk);
        check("tmo_no_swap", status, 4'h8);
`else
        repeat (200) @(negedge clk);
        check("stuck_render", status, 4'h3);
        check("stuck_activate", activate, 1'b1);
        worker_busy = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (status[2:0] !== 3'd0 && n < 20);
        check("stuck_done", status, 4'h0);
        check("stuck_line_bad", count_bad(12'hEEE), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
